// File: rtl/dcache_write_buffer.sv
// Data-cache write buffer: a small in-order FIFO between the dcache and the AXI bridge
// write port, with a line-granular read-after-write conflict check for pending reads.
module dcache_write_buffer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_req,
  input  logic [2:0]        wr_type,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [3:0]        wr_wstrb,
  input  logic [127:0]      wr_data,
  output logic              wr_rdy,
  output logic              out_wr_req,
  output logic [2:0]        out_wr_type,
  output logic [ADDR_W-1:0] out_wr_addr,
  output logic [3:0]        out_wr_wstrb,
  output logic [127:0]      out_wr_data,
  input  logic              out_wr_rdy,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_conflict,
  output logic              empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [PTR_W-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [2:0]        type_q  [DEPTH];
  logic [2:0]        type_d  [DEPTH];
  logic [ADDR_W-1:0] addr_q  [DEPTH];
  logic [ADDR_W-1:0] addr_d  [DEPTH];
  logic [3:0]        wstrb_q [DEPTH];
  logic [3:0]        wstrb_d [DEPTH];
  logic [127:0]      data_q  [DEPTH];
  logic [127:0]      data_d  [DEPTH];
  logic              push, pop;
  logic [PTR_W-1:0]  offs;

  // Both sides use valid/ready: a transfer happens on a cycle where req and rdy are
  // both high; a requester seeing rdy low must hold its request and payload unchanged.
  assign wr_rdy     = (count_q != FULL_CNT);
  assign out_wr_req = (count_q != '0);
  assign empty      = (count_q == '0);
  assign push       = wr_req && wr_rdy;
  assign pop        = out_wr_req && out_wr_rdy;

  // Head entry comes straight from storage, so the output port has no path from wr_*.
  assign out_wr_type  = type_q[rptr_q];
  assign out_wr_addr  = addr_q[rptr_q];
  assign out_wr_wstrb = wstrb_q[rptr_q];
  assign out_wr_data  = data_q[rptr_q];

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    type_d  = type_q;
    addr_d  = addr_q;
    wstrb_d = wstrb_q;
    data_d  = data_q;
    if (push) begin
      type_d[wptr_q]  = wr_type;
      addr_d[wptr_q]  = wr_addr;
      wstrb_d[wptr_q] = wr_wstrb;
      data_d[wptr_q]  = wr_data;
      wptr_d          = wptr_q + PTR_W'(1);
    end
    if (pop) begin
      rptr_d = rptr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // An entry being popped this cycle is still in flight, so it still blocks reads.
  always_comb begin
    offs        = '0;
    rd_conflict = push && (wr_addr[ADDR_W-1:4] == rd_addr[ADDR_W-1:4]);
    for (int i = 0; i < DEPTH; i++) begin
      offs = PTR_W'(i) - rptr_q;
      if (({1'b0, offs} < count_q) && (addr_q[i][ADDR_W-1:4] == rd_addr[ADDR_W-1:4])) begin
        rd_conflict = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        type_q[i]  <= '0;
        addr_q[i]  <= '0;
        wstrb_q[i] <= '0;
        data_q[i]  <= '0;
      end
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      type_q  <= type_d;
      addr_q  <= addr_d;
      wstrb_q <= wstrb_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: tb/tb_dcache_write_buffer.sv
// Directed bench for dcache_write_buffer: push/drain order, full and stall behaviour,
// wrap-around under concurrent push/pop, read conflicts and asynchronous reset.
module tb_dcache_write_buffer;

  logic         clk;
  logic         reset;
  logic         wr_req;
  logic [2:0]   wr_type;
  logic [31:0]  wr_addr;
  logic [3:0]   wr_wstrb;
  logic [127:0] wr_data;
  logic         wr_rdy;
  logic         out_wr_req;
  logic [2:0]   out_wr_type;
  logic [31:0]  out_wr_addr;
  logic [3:0]   out_wr_wstrb;
  logic [127:0] out_wr_data;
  logic         out_wr_rdy;
  logic [31:0]  rd_addr;
  logic         rd_conflict;
  logic         empty;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] head_addr;
  logic [127:0] head_data;

  dcache_write_buffer #(.DEPTH(4), .ADDR_W(32)) dut (
    .clk(clk), .reset(reset),
    .wr_req(wr_req), .wr_type(wr_type), .wr_addr(wr_addr), .wr_wstrb(wr_wstrb),
    .wr_data(wr_data), .wr_rdy(wr_rdy),
    .out_wr_req(out_wr_req), .out_wr_type(out_wr_type), .out_wr_addr(out_wr_addr),
    .out_wr_wstrb(out_wr_wstrb), .out_wr_data(out_wr_data), .out_wr_rdy(out_wr_rdy),
    .rd_addr(rd_addr), .rd_conflict(rd_conflict), .empty(empty)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // driver: present a write on the upstream port (line type, data derived from address)
  task automatic drive_push(input logic [31:0] a);
    wr_req   = 1'b1;
    wr_type  = 3'b100;
    wr_addr  = a;
    wr_wstrb = 4'hf;
    wr_data  = {a, ~a, a, 32'h0000_5a5a};
  endtask

  task automatic drive_idle();
    wr_req = 1'b0;
  endtask

  function automatic logic [127:0] data_of(input logic [31:0] a);
    return {a, ~a, a, 32'h0000_5a5a};
  endfunction

  initial begin
    reset = 1'b1; wr_req = 1'b0; wr_type = 3'b000; wr_addr = '0; wr_wstrb = '0;
    wr_data = '0; out_wr_rdy = 1'b0; rd_addr = '0;
    #2;
    // reset state
    chk("rst_wr_rdy", wr_rdy, 1);
    chk("rst_out_req", out_wr_req, 0);
    chk("rst_empty", empty, 1);
    chk("rst_out_addr", out_wr_addr, 0);
    chk("rst_out_data", out_wr_data, 0);
    chk("rst_conflict_idle", rd_conflict, 0);
    rd_addr = 32'h1c00_0048;
    drive_push(32'h1c00_0040);
    #1;
    chk("rst_conflict_incoming", rd_conflict, 1);
    drive_idle();
    rd_addr = '0;
    #10;
    reset = 1'b0;
    tick();

    // single push then pop
    drive_push(32'h1c00_0040);
    #1;
    chk("t1_rdy", wr_rdy, 1);
    chk("t1_empty_before", empty, 1);
    tick();
    drive_idle();
    #1;
    chk("t1_out_req", out_wr_req, 1);
    chk("t1_out_addr", out_wr_addr, 32'h1c00_0040);
    chk("t1_out_type", out_wr_type, 3'b100);
    chk("t1_out_data", out_wr_data, data_of(32'h1c00_0040));
    chk("t1_empty", empty, 0);
    out_wr_rdy = 1'b1;
    tick();
    out_wr_rdy = 1'b0;
    #1;
    chk("t1_empty_after", empty, 1);
    chk("t1_out_req_after", out_wr_req, 0);

    // fill to full, ignored fifth write, drain in order
    for (int i = 0; i < 4; i++) begin
      drive_push(32'h2000_0000 + 32'(i) * 32'h100);
      exp_q.push_back(32'h2000_0000 + 32'(i) * 32'h100);
      tick();
    end
    drive_idle();
    #1;
    chk("t2_full_rdy", wr_rdy, 0);
    chk("t2_full_empty", empty, 0);
    drive_push(32'hdead_0000);
    rd_addr = 32'hdead_0004;
    #1;
    chk("t2_full_no_incoming_conflict", rd_conflict, 0);
    tick();
    drive_idle();
    rd_addr = '0;
    #1;
    chk("t2_ignored_rdy", wr_rdy, 0);
    chk("t2_ignored_head", out_wr_addr, 32'h2000_0000);
    out_wr_rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("t2_drain_req", out_wr_req, 1);
      chk("t2_drain_addr", out_wr_addr, exp_q.pop_front());
      tick();
    end
    out_wr_rdy = 1'b0;
    #1;
    chk("t2_drained_empty", empty, 1);

    // head stays stable while stalled, pushes keep arriving
    drive_push(32'h3000_0000);
    exp_q.push_back(32'h3000_0000);
    tick();
    head_addr = 32'h3000_0000;
    head_data = data_of(32'h3000_0000);
    for (int i = 0; i < 10; i++) begin
      drive_push(32'h3000_1000 + 32'(i) * 32'h10);
      if (i < 3) exp_q.push_back(32'h3000_1000 + 32'(i) * 32'h10);
      #1;
      chk("t3_stall_addr", out_wr_addr, head_addr);
      chk("t3_stall_data", out_wr_data, head_data);
      tick();
    end
    drive_idle();
    out_wr_rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("t3_drain_addr", out_wr_addr, exp_q.pop_front());
      tick();
    end
    out_wr_rdy = 1'b0;
    #1;
    chk("t3_drained_empty", empty, 1);

    // concurrent push/pop at occupancy 2 across pointer wrap
    for (int i = 0; i < 2; i++) begin
      drive_push(32'h4000_0000 + 32'(i) * 32'h20);
      exp_q.push_back(32'h4000_0000 + 32'(i) * 32'h20);
      tick();
    end
    for (int i = 0; i < 8; i++) begin
      drive_push(32'h4000_0000 + 32'(i + 2) * 32'h20);
      out_wr_rdy = 1'b1;
      #1;
      chk("t4_rdy", wr_rdy, 1);
      chk("t4_head", out_wr_addr, exp_q[0]);
      tick();
      void'(exp_q.pop_front());
      exp_q.push_back(32'h4000_0000 + 32'(i + 2) * 32'h20);
    end
    drive_idle();
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("t4_tail_req", out_wr_req, 1);
      chk("t4_tail_addr", out_wr_addr, exp_q.pop_front());
      tick();
    end
    out_wr_rdy = 1'b0;
    #1;
    chk("t4_count_was_2", empty, 1);

    // read conflicts
    drive_push(32'h1c00_0044);
    tick();
    drive_idle();
    rd_addr = 32'h1c00_004c;
    #1;
    chk("t5_conflict_buffered", rd_conflict, 1);
    rd_addr = 32'h1c00_0050;
    #1;
    chk("t5_no_conflict", rd_conflict, 0);
    drive_push(32'h1c00_0050);
    #1;
    chk("t5_conflict_incoming", rd_conflict, 1);
    drive_idle();
    rd_addr = 32'h1c00_0048;
    out_wr_rdy = 1'b1;
    #1;
    chk("t5_conflict_popping", rd_conflict, 1);
    tick();
    out_wr_rdy = 1'b0;
    #1;
    chk("t5_conflict_gone", rd_conflict, 0);
    chk("t5_empty", empty, 1);

    // asynchronous reset with a stalled head
    for (int i = 0; i < 3; i++) begin
      drive_push(32'h5000_0000 + 32'(i) * 32'h40);
      tick();
    end
    drive_idle();
    rd_addr = 32'h5000_0000;
    #1;
    chk("t6_pre_req", out_wr_req, 1);
    chk("t6_pre_conflict", rd_conflict, 1);
    reset = 1'b1;
    #1;
    chk("t6_rst_req", out_wr_req, 0);
    chk("t6_rst_empty", empty, 1);
    chk("t6_rst_rdy", wr_rdy, 1);
    chk("t6_rst_addr", out_wr_addr, 0);
    chk("t6_rst_conflict", rd_conflict, 0);
    #2;
    reset = 1'b0;
    tick();
    drive_push(32'h6000_0000);
    tick();
    drive_idle();
    #1;
    chk("t6_post_head", out_wr_addr, 32'h6000_0000);
    out_wr_rdy = 1'b1;
    tick();
    out_wr_rdy = 1'b0;
    #1;
    chk("t6_post_empty", empty, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dcache_write_buffer.md
DCACHE_WRITE_BUFFER -- requirements
Module: dcache_write_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of buffered write entries (power of two, >= 2).
REQ-002 SHALL have parameter ADDR_W, default 32, write address width.
REQ-003 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port wr_req  input  1  dcache write request, upstream side.
REQ-006 SHALL have port wr_type  input  3  write type (3'b100 = cache line, 3'b000/001/010 = byte/half/word uncached).
REQ-007 SHALL have port wr_addr  input  ADDR_W  write address.
REQ-008 SHALL have port wr_wstrb  input  4  byte strobe for uncached writes.
REQ-009 SHALL have port wr_data  input  128  write data (line, or word in [31:0]).
REQ-010 SHALL have port wr_rdy  output  1  buffer can accept a write this cycle.
REQ-011 SHALL have ports out_wr_req/out_wr_type/out_wr_addr/out_wr_wstrb/out_wr_data  output  1/3/ADDR_W/4/128  head entry presented to axi_bridge data write port.
REQ-012 SHALL have port out_wr_rdy  input  1  axi_bridge accepts the presented head entry.
REQ-013 SHALL have port rd_addr  input  ADDR_W  address of a pending dcache read request.
REQ-014 SHALL have port rd_conflict  output  1  rd_addr hits a buffered or incoming write.
REQ-015 SHALL have port empty  output  1  no entries buffered (drives axi_bridge write_buffer_empty).

Function
REQ-016 SHALL store entries in a circular FIFO with write pointer, read pointer (log2(DEPTH) bits, wrap DEPTH-1 -> 0) and count (0..DEPTH).
REQ-017 SHALL drive wr_rdy = (count != DEPTH); no same-cycle bypass when full.
REQ-018 SHALL push {wr_type, wr_addr, wr_wstrb, wr_data} at wptr and advance wptr when wr_req && wr_rdy.
REQ-019 SHALL drive out_wr_req = (count != 0) and out_wr_* from the entry at rptr, all registered-state-derived (no combinational path from wr_* to out_wr_*).
REQ-020 SHALL pop (advance rptr) when out_wr_req && out_wr_rdy; out_wr_* SHALL hold stable while out_wr_req && !out_wr_rdy.
REQ-021 SHALL give push-to-out_wr_req latency of exactly 1 cycle when empty.
REQ-022 SHALL on simultaneous push and pop leave count unchanged and advance both pointers.
REQ-023 SHALL preserve strict FIFO order; entries never merged or reordered.
REQ-024 SHALL compute rd_conflict combinationally = OR over valid entries of (entry addr[ADDR_W-1:4] == rd_addr[ADDR_W-1:4]), OR'd with the same compare against wr_addr when wr_req && wr_rdy.
REQ-025 SHALL treat an entry popped this cycle as still valid for rd_conflict in that cycle.
REQ-026 SHALL drive empty = (count == 0).
REQ-027 SHALL ignore wr_req when wr_rdy = 0 (no state change; requester holds request).

Reset
REQ-028 SHALL on reset assertion immediately clear wptr, rptr, count; outputs become wr_rdy=1, out_wr_req=0, empty=1, rd_conflict depends only on incoming wr_req compare.
REQ-029 SHALL discard all buffered entries on reset mid-operation, including one presented but not yet accepted.
REQ-030 SHALL reset-clear out_wr_type/addr/wstrb/data storage to 0.

Verification
REQ-031 Single push: wr_req=1, wr_addr=0x1C000040, wr_type=3'b100 -> next cycle out_wr_req=1, out_wr_addr=0x1C000040, empty=0; out_wr_rdy=1 -> following cycle empty=1.
REQ-032 Fill: 4 pushes with out_wr_rdy=0 -> wr_rdy=0 after 4th; 5th wr_req ignored; drain yields addresses in push order.
REQ-033 Stall stability: out_wr_rdy=0 for 10 cycles with pushes arriving -> out_wr_* constant throughout.
REQ-034 Concurrent push/pop at count=2 -> count stays 2, pointers advance, wrap past index 3 -> 0 correct over 8 transactions.
REQ-035 Conflict: buffered addr 0x1C000044, rd_addr=0x1C00004C -> rd_conflict=1; rd_addr=0x1C000050 -> 0; incoming wr_addr=0x1C000050 same cycle -> 1.
REQ-036 Reset with 3 entries buffered and head stalled -> out_wr_req=0, empty=1, wr_rdy=1 immediately, before next clk edge.
